// File: rtl/dmux_stream_nway_pkg.sv
// rtl/dmux_stream_nway_pkg.sv - shared slot-state encoding and counter width for dmux_stream_nway
// Purpose: definitions shared by the demux top level and its per-channel slots.
//   slot_state_e : per-slot occupancy, EMPTY (no word) or FULL (word waiting for sink)
//   DMUX_CNT_W   : width of each per-channel drain counter (statistics build only)
package dmux_stream_nway_pkg;

    typedef enum logic {
        DMUX_EMPTY = 1'b0,
        DMUX_FULL  = 1'b1
    } slot_state_e;

    localparam int DMUX_CNT_W = 16;

endpackage

// File: rtl/dmux_slot.sv
// rtl/dmux_slot.sv - one output channel register slice of dmux_stream_nway
// Purpose: holds one channel's data word and its EMPTY/FULL state, with an
//   optional drain counter when DMUX_STREAM_STATS_EN is defined.
// Ports:
//   clock, reset      rising-edge clock, asynchronous active-high reset
//   fill              top level accepted a word for this channel this cycle
//   data_in           word to load on fill
//   out_ready         sink takes the word this cycle
//   out_valid         slot is FULL
//   out_data          held word (last value retained while EMPTY)
//   cnt_clr, cnt      synchronous counter clear and drain count (DMUX_STREAM_STATS_EN only)
module dmux_slot
    import dmux_stream_nway_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fill,
    input  logic [WIDTH-1:0]      data_in,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data
`ifdef DMUX_STREAM_STATS_EN
    ,
    input  logic                  cnt_clr,
    output logic [DMUX_CNT_W-1:0] cnt
`endif
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             drain;

    assign drain = (state_q == DMUX_FULL) && out_ready;

    // A fill takes priority over a drain: a drain and fill in the same cycle
    // hand the old word to the sink and load the new one with no bubble.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (fill) begin
            state_d = DMUX_FULL;
            data_d  = data_in;
        end else if (drain) begin
            state_d = DMUX_EMPTY;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DMUX_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == DMUX_FULL);
    assign out_data  = data_q;

`ifdef DMUX_STREAM_STATS_EN
    logic [DMUX_CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a simultaneous drain; the counter wraps naturally.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = '0;
        end else if (drain) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`endif

endmodule

// File: rtl/dmux_stream_nway.sv
// rtl/dmux_stream_nway.sv - registered flow-controlled 1-to-N stream demultiplexer
// Purpose: routes WIDTH-bit words to one of CHANNELS registered output slots
//   chosen by in_sel, each with its own valid/ready back-pressure.
//   Optional macro DMUX_STREAM_STATS_EN adds per-channel drain counters.
// Ports:
//   clock, reset   rising-edge clock, asynchronous active-high reset
//   in_data        input word
//   in_sel         destination channel index
//   in_valid       producer has a word
//   in_ready       word accepted this cycle (independent of in_valid)
//   out_data       flattened slots, channel k = [k*WIDTH +: WIDTH]
//   out_valid      per-channel slot full
//   out_ready      per-channel sink ready
//   cnt_clr        synchronous clear of all counters (DMUX_STREAM_STATS_EN only)
//   cnt_out        per-channel drain counts, [k*16 +: 16] (DMUX_STREAM_STATS_EN only)
//   sel_err        one-cycle pulse after an out-of-range word was dropped
module dmux_stream_nway
    import dmux_stream_nway_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [WIDTH-1:0]               in_data,
    input  logic [SEL_W-1:0]               in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [CHANNELS*WIDTH-1:0]      out_data,
    output logic [CHANNELS-1:0]            out_valid,
    input  logic [CHANNELS-1:0]            out_ready,
`ifdef DMUX_STREAM_STATS_EN
    input  logic                           cnt_clr,
    output logic [CHANNELS*DMUX_CNT_W-1:0] cnt_out,
`endif
    output logic                           sel_err
);

    logic [CHANNELS-1:0] sel_hit;
    logic [CHANNELS-1:0] fill;
    logic                sel_busy;
    logic                accept;
    logic                sel_err_q, sel_err_d;

    // Decode by comparison against every legal index so an out-of-range
    // select simply hits nothing and is never treated as busy.
    always_comb begin
        sel_hit  = '0;
        sel_busy = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (int'(in_sel) == k) begin
                sel_hit[k] = 1'b1;
                sel_busy   = out_valid[k] & ~out_ready[k];
            end
        end
    end

    assign in_ready  = ~sel_busy;
    assign accept    = in_valid & in_ready;
    assign fill      = sel_hit & {CHANNELS{accept}};
    assign sel_err_d = accept & ~(|sel_hit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel_err_q <= 1'b0;
        end else begin
            sel_err_q <= sel_err_d;
        end
    end

    assign sel_err = sel_err_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        dmux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .fill      (fill[k]),
            .data_in   (in_data),
            .out_ready (out_ready[k]),
            .out_valid (out_valid[k]),
            .out_data  (out_data[k*WIDTH +: WIDTH])
`ifdef DMUX_STREAM_STATS_EN
            ,
            .cnt_clr   (cnt_clr),
            .cnt       (cnt_out[k*DMUX_CNT_W +: DMUX_CNT_W])
`endif
        );
    end

endmodule

// File: tb/tb_dmux_stream_nway.sv
// tb/tb_dmux_stream_nway.sv - self-checking bench for dmux_stream_nway (4-channel and 3-channel instances)
module tb_dmux_stream_nway;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic [1:0]  sel0, sel1;
    logic        rdy0, rdy1;
    logic [63:0] od0;
    logic [47:0] od1;
    logic [3:0]  ov0, or0;
    logic [2:0]  ov1, or1;
    logic        err0, err1;
`ifdef DMUX_STREAM_STATS_EN
    logic        clr;
    logic [63:0] cnt0;
    logic [47:0] cnt1;
`endif

    always #5 clk = ~clk;

    dmux_stream_nway #(.WIDTH(16), .CHANNELS(4)) dut4 (
        .clock(clk), .reset(rst), .in_data(in_data), .in_sel(sel0), .in_valid(in_valid),
        .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(or0),
`ifdef DMUX_STREAM_STATS_EN
        .cnt_clr(clr), .cnt_out(cnt0),
`endif
        .sel_err(err0)
    );

    dmux_stream_nway #(.WIDTH(16), .CHANNELS(3)) dut3 (
        .clock(clk), .reset(rst), .in_data(in_data), .in_sel(sel1), .in_valid(in_valid),
        .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(or1),
`ifdef DMUX_STREAM_STATS_EN
        .cnt_clr(clr), .cnt_out(cnt1),
`endif
        .sel_err(err1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: per instance, a list of occupied slots and held words.
    int          nch [2] = '{4, 3};
    bit          mv  [2][4];
    logic [15:0] md  [2][4];
    bit          merr[2];

    function automatic int get_sel(input int d);
        return (d == 0) ? int'(sel0) : int'(sel1);
    endfunction

    function automatic bit get_ordy(input int d, input int k);
        logic [3:0] t;
        t = (d == 0) ? or0 : {1'b0, or1};
        return t[k];
    endfunction

    function automatic bit model_ready(input int d);
        int s;
        s = get_sel(d);
        if (s >= nch[d]) return 1'b1;
        return !mv[d][s] || get_ordy(d, s);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            merr[d] = 1'b0;
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = 1'b0;
                md[d][k] = 16'h0;
            end
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit acc;
            int s;
            acc = in_valid && model_ready(d);
            s   = get_sel(d);
            for (int k = 0; k < nch[d]; k++)
                if (mv[d][k] && get_ordy(d, k)) mv[d][k] = 1'b0;
            merr[d] = acc && (s >= nch[d]);
            if (acc && s < nch[d]) begin
                mv[d][s] = 1'b1;
                md[d][s] = in_data;
            end
        end
    endtask

    task automatic check_outs();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("m4_valid%0d", k), 64'(ov0[k]), 64'(mv[0][k]));
            chk($sformatf("m4_data%0d", k), 64'(od0[k*16 +: 16]), 64'(md[0][k]));
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("m3_valid%0d", k), 64'(ov1[k]), 64'(mv[1][k]));
            chk($sformatf("m3_data%0d", k), 64'(od1[k*16 +: 16]), 64'(md[1][k]));
        end
        chk("m4_sel_err", 64'(err0), 64'(merr[0]));
        chk("m3_sel_err", 64'(err1), 64'(merr[1]));
    endtask

    // Inputs are set just after a rising edge; this checks in_ready, advances
    // the model across the next edge and checks registered outputs after it.
    task automatic step_checked();
        #1;
        chk("m4_in_ready", 64'(rdy0), 64'(model_ready(0)));
        chk("m3_in_ready", 64'(rdy1), 64'(model_ready(1)));
        model_edge();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic [15:0] data;
        logic        v;
        logic [3:0]  ordy;
        logic        exp_rdy;
        logic [3:0]  exp_ov;
        int          ch;
        logic [15:0] exp_d;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{2'd2, 16'h1234, 1'b1, 4'b0000, 1'b1, 4'b0100, 2, 16'h1234};
        tbl[1] = '{2'd0, 16'h00A0, 1'b1, 4'b0000, 1'b1, 4'b0101, 0, 16'h00A0};
        tbl[2] = '{2'd0, 16'h00B0, 1'b1, 4'b0000, 1'b0, 4'b0101, 0, 16'h00A0};
        tbl[3] = '{2'd0, 16'h00B0, 1'b1, 4'b0001, 1'b1, 4'b0101, 0, 16'h00B0};
        tbl[4] = '{2'd3, 16'h3333, 1'b0, 4'b0101, 1'b1, 4'b0000, 2, 16'h1234};
        tbl[5] = '{2'd1, 16'h1111, 1'b1, 4'b0000, 1'b1, 4'b0010, 1, 16'h1111};

        rst = 1'b1; in_valid = 1'b0; in_data = '0;
        sel0 = '0; sel1 = '0; or0 = '0; or1 = '0;
`ifdef DMUX_STREAM_STATS_EN
        clr = 1'b0;
`endif
        #2;
        chk("reset_valid4", 64'(ov0), 64'h0);
        chk("reset_data4", od0, 64'h0);
        chk("reset_err4", 64'(err0), 64'h0);
        chk("reset_valid3", 64'(ov1), 64'h0);
        chk("reset_ready4", 64'(rdy0), 64'h1);
        do_reset();

        // Table vectors on the 4-channel instance.
        for (int i = 0; i < 6; i++) begin
            sel0 = tbl[i].sel; in_data = tbl[i].data; in_valid = tbl[i].v; or0 = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_ready", i), 64'(rdy0), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_valid", i), 64'(ov0), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_data", i), 64'(od0[tbl[i].ch*16 +: 16]), 64'(tbl[i].exp_d));
        end

        // Reset asserted between edges while ch1 holds a word.
        do_reset();
        sel0 = 2'd1; in_data = 16'hBEEF; in_valid = 1'b1; or0 = 4'b0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("rst_mid_loaded", 64'(od0[31:16]), 64'hBEEF);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_valid", 64'(ov0), 64'h0);
        chk("rst_mid_data", od0, 64'h0);
        #2 rst = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_ready_v0", 64'(rdy0), 64'h1);
        in_valid = 1'b1;
        #1;
        chk("rst_mid_ready_v1", 64'(rdy0), 64'h1);
        in_valid = 1'b0;

        // Isolation: ch3 stalled FULL while ch0..2 each take a word.
        do_reset();
        or0 = 4'b0000; sel0 = 2'd3; in_data = 16'h0033; in_valid = 1'b1;
        step_checked();
        for (int i = 0; i < 3; i++) begin
            sel0 = 2'(i); in_data = 16'h00A0 + 16'(i);
            #1;
            chk($sformatf("iso_ready%0d", i), 64'(rdy0), 64'h1);
            step_checked();
        end
        chk("iso_ch3_data", 64'(od0[63:48]), 64'h0033);
        chk("iso_valid", 64'(ov0), 64'hF);

        // Streaming into a never-stalled channel.
        do_reset();
        or0 = 4'b0010; sel0 = 2'd1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 16'h0100 + 16'(i);
            step_checked();
            chk($sformatf("stream_valid%0d", i), 64'(ov0[1]), 64'h1);
            chk($sformatf("stream_data%0d", i), 64'(od0[31:16]), 64'h0100 + 64'(i));
        end
        in_valid = 1'b0;
        step_checked();

        // Out-of-range select on the 3-channel instance.
        do_reset();
        or1 = 3'b000; sel1 = 2'd3; in_data = 16'h0055; in_valid = 1'b1;
        #1;
        chk("oor_ready", 64'(rdy1), 64'h1);
        step_checked();
        chk("oor_err_pulse", 64'(err1), 64'h1);
        chk("oor_no_fill", 64'(ov1), 64'h0);
        in_valid = 1'b0;
        step_checked();
        chk("oor_err_clear", 64'(err1), 64'h0);

`ifdef DMUX_STREAM_STATS_EN
        do_reset();
        or1 = 3'b001; sel1 = 2'd0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) step_checked();
        in_valid = 1'b0;
        step_checked();
        chk("cnt_three", 64'(cnt1[15:0]), 64'h3);
        clr = 1'b1;
        step_checked();
        clr = 1'b0;
        chk("cnt_cleared", 64'(cnt1[15:0]), 64'h0);
`endif

        // Randomized traffic against the model on both instances.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 16'($urandom);
            sel0     = 2'($urandom_range(0, 3));
            sel1     = 2'($urandom_range(0, 3));
            or0      = 4'($urandom);
            or1      = 3'($urandom);
            step_checked();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
